// File: rtl/pio_pattern_sequencer.sv
// Plays a programmable table of pattern values onto an Avalon-MM output PIO at a fixed step period.
// The Nios programs it through its own CSR slave; the PIO is driven through a write-only master.
module pio_pattern_sequencer #(
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned HOLD_W = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [3:0]  s_address,
  input  logic        s_chipselect,
  input  logic        s_write_n,
  input  logic [31:0] s_writedata,
  output logic [31:0] s_readdata,
  output logic [1:0]  m_address,
  output logic        m_chipselect,
  output logic        m_write_n,
  output logic [31:0] m_writedata,
  output logic        irq
);

  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned LEN_W = 4;
  localparam logic [LEN_W-1:0] DEPTH_L = LEN_W'(DEPTH);

  typedef enum logic [1:0] {ST_IDLE, ST_WRITE, ST_HOLD} state_t;

  state_t            state, state_d;
  logic [IDX_W-1:0]  idx, idx_d;
  logic [LEN_W-1:0]  len_q, length_q, len_clamp;
  logic [HOLD_W-1:0] hold_q, cnt;
  logic [DATA_W-1:0] pattern [DEPTH];
  logic [DATA_W-1:0] pat_q;
  logic              loop_q, irq_en_q, done_q;
  logic              csr_we, ctrl_we, start, stop, done_clr;
  logic              step_end, enter_write, set_done, done_d, irq_en_d;
  logic              unused_wdata;

  assign m_address    = 2'b00;
  assign unused_wdata = ^{s_writedata, 1'b0};

  // CSR strobes and step-boundary detection
  always_comb begin
    csr_we    = s_chipselect && !s_write_n;
    ctrl_we   = csr_we && (s_address == 4'd0);
    start     = ctrl_we && s_writedata[0];
    stop      = ctrl_we && s_writedata[2];
    done_clr  = csr_we && (s_address == 4'd1) && s_writedata[1];
    len_clamp = (length_q > DEPTH_L) ? DEPTH_L : length_q;
    step_end  = ((state == ST_WRITE) && (cnt == '0)) ||
                ((state == ST_HOLD) && (cnt == HOLD_W'(1)));
  end

  // Next-state logic; the step-advance decision folds into the last cycle of a step
  always_comb begin
    state_d     = state;
    idx_d       = idx;
    enter_write = 1'b0;
    set_done    = 1'b0;
    if (stop) begin
      state_d = ST_IDLE;
    end else if (state == ST_IDLE) begin
      if (start && (length_q != '0)) begin
        state_d     = ST_WRITE;
        idx_d       = '0;
        enter_write = 1'b1;
      end
    end else if (step_end) begin
      if ((LEN_W'(idx) + LEN_W'(1)) < len_q) begin
        state_d     = ST_WRITE;
        idx_d       = idx + IDX_W'(1);
        enter_write = 1'b1;
      end else if (loop_q) begin
        state_d     = ST_WRITE;
        idx_d       = '0;
        enter_write = 1'b1;
      end else begin
        state_d  = ST_IDLE;
        set_done = 1'b1;
      end
    end else if (state == ST_WRITE) begin
      state_d = ST_HOLD;
    end
    done_d   = set_done || (done_q && !done_clr);
    irq_en_d = ctrl_we ? s_writedata[3] : irq_en_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= ST_IDLE;
      idx          <= '0;
      len_q        <= '0;
      length_q     <= '0;
      hold_q       <= '0;
      cnt          <= '0;
      pat_q        <= '0;
      loop_q       <= 1'b0;
      irq_en_q     <= 1'b0;
      done_q       <= 1'b0;
      irq          <= 1'b0;
      m_chipselect <= 1'b0;
      m_write_n    <= 1'b1;
      m_writedata  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) pattern[i] <= '0;
    end else begin
      state    <= state_d;
      idx      <= idx_d;
      done_q   <= done_d;
      irq_en_q <= irq_en_d;
      irq      <= done_d && irq_en_d;
      if ((state == ST_IDLE) && enter_write) len_q <= len_clamp;
      // Pattern and hold are sampled as each step starts, so live edits land on later steps
      if (enter_write) begin
        pat_q <= pattern[idx_d];
        cnt   <= (hold_q == '0) ? '0 : hold_q - HOLD_W'(1);
      end else if (state == ST_HOLD) begin
        cnt <= cnt - HOLD_W'(1);
      end
      m_chipselect <= (state == ST_WRITE);
      m_write_n    <= (state != ST_WRITE);
      if (state == ST_WRITE) m_writedata <= 32'(pat_q);
      if (ctrl_we) loop_q <= s_writedata[1];
      if (csr_we && (s_address == 4'd2)) length_q <= s_writedata[LEN_W-1:0];
      if (csr_we && (s_address == 4'd3)) hold_q <= s_writedata[HOLD_W-1:0];
      for (int i = 0; i < int'(DEPTH); i++)
        if (csr_we && (s_address == 4'(8 + i))) pattern[i] <= s_writedata[DATA_W-1:0];
    end
  end

  // Zero-wait-state CSR read mux
  always_comb begin
    s_readdata = '0;
    case (s_address)
      4'd0: s_readdata = {28'd0, irq_en_q, 1'b0, loop_q, 1'b0};
      4'd1: s_readdata = {25'd0, 3'(idx), 2'b00, done_q, (state != ST_IDLE)};
      4'd2: s_readdata = 32'(length_q);
      4'd3: s_readdata = 32'(hold_q);
      default: begin
        for (int i = 0; i < int'(DEPTH); i++)
          if (s_address == 4'(8 + i)) s_readdata = 32'(pattern[i]);
      end
    endcase
  end

endmodule

// File: tb/tb_pio_pattern_sequencer.sv
// Bench for pio_pattern_sequencer: directed and randomized playbacks checked against
// a timeline model (write k lands at start+2+k*period with table entry k mod length).
module tb_pio_pattern_sequencer;
  localparam int unsigned DEPTH = 8;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [3:0]  s_address = '0;
  logic        s_chipselect = 1'b0;
  logic        s_write_n = 1'b1;
  logic [31:0] s_writedata = '0;
  logic [31:0] s_readdata;
  logic [1:0]  m_address;
  logic        m_chipselect;
  logic        m_write_n;
  logic [31:0] m_writedata;
  logic        irq;

  pio_pattern_sequencer #(.DEPTH(DEPTH), .DATA_W(8), .HOLD_W(16)) dut (
    .clk(clk), .reset_n(reset_n),
    .s_address(s_address), .s_chipselect(s_chipselect), .s_write_n(s_write_n),
    .s_writedata(s_writedata), .s_readdata(s_readdata),
    .m_address(m_address), .m_chipselect(m_chipselect), .m_write_n(m_write_n),
    .m_writedata(m_writedata), .irq(irq)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_err = 0;
  int          edge_n = 0;
  int          wr_edge[$];
  logic [31:0] wr_data[$];
  logic [7:0]  pio_out = 8'h00;

  // PIO side: log every accepted write with the edge index that captured it
  always @(posedge clk) begin
    if (reset_n && m_chipselect && !m_write_n) begin
      wr_edge.push_back(edge_n);
      wr_data.push_back(m_writedata);
      pio_out <= m_writedata[7:0];
    end
    edge_n <= edge_n + 1;
  end

  logic [7:0] pat_m [DEPTH];
  int         len_m = 0;
  int         hold_m = 0;
  bit         loop_m = 1'b0;
  bit         irqen_m = 1'b0;
  logic [7:0] exp_pat [DEPTH];
  int         exp_len = 0;
  int         exp_per = 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_cmp++;
    assert (obs === want) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, want);
    end
  endtask

  task automatic csr_wr(input logic [3:0] a, input logic [31:0] d, output int t);
    @(negedge clk);
    t = edge_n;
    s_chipselect = 1'b1; s_write_n = 1'b0; s_address = a; s_writedata = d;
    @(negedge clk);
    s_chipselect = 1'b0; s_write_n = 1'b1;
    case (a)
      4'd0: begin loop_m = d[1]; irqen_m = d[3]; end
      4'd2: len_m = int'(d[3:0]);
      4'd3: hold_m = int'(d[15:0]);
      default: if (int'(a) >= 8) pat_m[int'(a) - 8] = d[7:0];
    endcase
  endtask

  task automatic csr_rd(input logic [3:0] a, output logic [31:0] d);
    s_address = a;
    #1;
    d = s_readdata;
  endtask

  task automatic check_play(input string tag, input int t, input int n);
    chk({tag, " count"}, 32'(wr_edge.size()), 32'(n));
    for (int k = 0; k < n && k < wr_edge.size(); k++) begin
      chk($sformatf("%s edge%0d", tag, k), 32'(wr_edge[k]), 32'(t + 2 + k * exp_per));
      chk($sformatf("%s data%0d", tag, k), wr_data[k], {24'd0, exp_pat[k % exp_len]});
    end
  endtask

  task automatic start_play(input logic [31:0] ctrl, output int t);
    exp_pat = pat_m;
    exp_len = (len_m > int'(DEPTH)) ? int'(DEPTH) : len_m;
    exp_per = (hold_m == 0) ? 1 : hold_m;
    wr_edge.delete();
    wr_data.delete();
    csr_wr(4'd0, ctrl | 32'h1, t);
  endtask

  task automatic finish_play(input string tag, input int t);
    logic [31:0] rd;
    int          tt;
    while (edge_n < t + exp_len * exp_per + 6) @(negedge clk);
    check_play(tag, t, exp_len);
    csr_rd(4'd1, rd);
    chk({tag, " status done"}, rd, 32'(((exp_len - 1) << 4) | 2));
    chk({tag, " irq"}, {31'd0, irq}, {31'd0, irqen_m});
    csr_wr(4'd1, 32'h2, tt);
    csr_rd(4'd1, rd);
    chk({tag, " status clr"}, rd, 32'((exp_len - 1) << 4));
    chk({tag, " irq clr"}, {31'd0, irq}, 32'd0);
  endtask

  initial begin
    logic [31:0] rd;
    logic [7:0]  pio_before;
    int          t, s, x, n, nw;

    for (int i = 0; i < int'(DEPTH); i++) pat_m[i] = 8'h00;

    // Reset values
    repeat (3) @(negedge clk);
    chk("rst m_chipselect", {31'd0, m_chipselect}, 32'd0);
    chk("rst m_write_n", {31'd0, m_write_n}, 32'd1);
    chk("rst m_address", {30'd0, m_address}, 32'd0);
    chk("rst m_writedata", m_writedata, 32'd0);
    chk("rst irq", {31'd0, irq}, 32'd0);
    csr_rd(4'd1, rd); chk("rst status", rd, 32'd0);
    csr_rd(4'd3, rd); chk("rst hold", rd, 32'd0);
    csr_rd(4'd5, rd); chk("rst unmapped", rd, 32'd0);
    reset_n = 1'b1;

    // One-shot with exact DONE timing
    csr_wr(4'd8, 32'h11, x); csr_wr(4'd9, 32'h22, x); csr_wr(4'd10, 32'h33, x);
    csr_wr(4'd2, 32'd3, x); csr_wr(4'd3, 32'd4, x);
    csr_rd(4'd9, rd); chk("pattern readback", rd, 32'h22);
    start_play(32'h0, t);
    while (edge_n < t + 12) @(negedge clk);
    csr_rd(4'd1, rd); chk("oneshot busy before done", rd & 32'h3, 32'h1);
    @(negedge clk);
    csr_rd(4'd1, rd); chk("oneshot done edge", rd, 32'h22);
    chk("oneshot irq masked", {31'd0, irq}, 32'd0);
    finish_play("oneshot", t);
    chk("oneshot pio_out", {24'd0, pio_out}, 32'h33);
    start_play(32'h8, t);
    finish_play("oneshot irq_en", t);

    // HOLD=0 and HOLD=1: back-to-back writes
    csr_wr(4'd8, 32'hA5, x); csr_wr(4'd9, 32'h5A, x); csr_wr(4'd2, 32'd2, x);
    csr_wr(4'd3, 32'd0, x);
    start_play(32'h0, t);
    finish_play("hold0", t);
    csr_wr(4'd3, 32'd1, x);
    start_play(32'h0, t);
    finish_play("hold1", t);

    // Loop then STOP: writes through the one already launched, then nothing, no DONE
    csr_wr(4'd8, 32'($urandom_range(255, 0)), x); csr_wr(4'd9, 32'($urandom_range(255, 0)), x);
    csr_wr(4'd2, 32'd2, x); csr_wr(4'd3, 32'd3, x);
    start_play(32'h2, t);
    while (edge_n < t + 12) @(negedge clk);
    csr_wr(4'd0, 32'h4, s);
    repeat (10) @(negedge clk);
    n = 0;
    for (int k = 0; t + 2 + k * 3 <= s + 1; k++) n++;
    check_play("loop_stop", t, n);
    csr_rd(4'd1, rd); chk("loop_stop status", rd & 32'h3, 32'h0);
    chk("loop_stop irq", {31'd0, irq}, 32'd0);

    // LENGTH=0 start is ignored
    csr_wr(4'd2, 32'd0, x);
    wr_edge.delete(); wr_data.delete();
    csr_wr(4'd0, 32'h1, t);
    csr_rd(4'd1, rd); chk("len0 busy", rd & 32'h3, 32'h0);
    repeat (8) @(negedge clk);
    chk("len0 writes", 32'(wr_edge.size()), 32'd0);

    // START|STOP together: STOP wins
    csr_wr(4'd2, 32'd3, x);
    wr_edge.delete(); wr_data.delete();
    csr_wr(4'd0, 32'h5, t);
    repeat (8) @(negedge clk);
    chk("start_stop writes", 32'(wr_edge.size()), 32'd0);
    csr_rd(4'd1, rd); chk("start_stop status", rd & 32'h3, 32'h0);

    // START during BUSY is ignored
    csr_wr(4'd3, 32'd4, x);
    start_play(32'h0, t);
    while (edge_n < t + 3) @(negedge clk);
    csr_wr(4'd0, 32'h1, x);
    finish_play("restart_ignored", t);

    // LENGTH above DEPTH clamps
    for (int i = 0; i < int'(DEPTH); i++) csr_wr(4'(8 + i), 32'($urandom_range(255, 0)), x);
    csr_wr(4'd2, 32'd15, x); csr_wr(4'd3, 32'd2, x);
    csr_rd(4'd2, rd); chk("length readback", rd, 32'd15);
    start_play(32'h0, t);
    finish_play("len15", t);

    // Live PATTERN[1] edit while step 0 holds
    csr_wr(4'd8, 32'h10, x); csr_wr(4'd9, 32'h20, x);
    csr_wr(4'd2, 32'd2, x); csr_wr(4'd3, 32'd6, x);
    start_play(32'h0, t);
    while (edge_n < t + 2) @(negedge clk);
    csr_wr(4'd9, 32'h77, x);
    exp_pat[1] = 8'h77;
    finish_play("live_update", t);

    // Randomized one-shot playbacks
    for (int it = 0; it < 6; it++) begin
      for (int i = 0; i < int'(DEPTH); i++) csr_wr(4'(8 + i), 32'($urandom_range(255, 0)), x);
      csr_wr(4'd2, 32'($urandom_range(15, 1)), x);
      csr_wr(4'd3, 32'($urandom_range(5, 0)), x);
      start_play(($urandom_range(1, 0) == 1) ? 32'h8 : 32'h0, t);
      finish_play($sformatf("rand%0d", it), t);
    end

    // Reset in the middle of playback
    csr_wr(4'd2, 32'd8, x); csr_wr(4'd3, 32'd5, x);
    start_play(32'h8, t);
    while (edge_n < t + 14) @(negedge clk);
    pio_before = pio_out;
    nw = wr_edge.size();
    reset_n = 1'b0;
    #1;
    chk("midrst m_chipselect", {31'd0, m_chipselect}, 32'd0);
    chk("midrst m_write_n", {31'd0, m_write_n}, 32'd1);
    chk("midrst m_writedata", m_writedata, 32'd0);
    chk("midrst irq", {31'd0, irq}, 32'd0);
    csr_rd(4'd1, rd); chk("midrst status", rd, 32'd0);
    csr_rd(4'd0, rd); chk("midrst ctrl", rd, 32'd0);
    csr_rd(4'd2, rd); chk("midrst length", rd, 32'd0);
    repeat (3) @(negedge clk);
    chk("midrst no writes", 32'(wr_edge.size()), 32'(nw));
    chk("midrst pio_out", {24'd0, pio_out}, {24'd0, pio_before});
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pio_pattern_sequencer.md
# pio_pattern_sequencer

Hardware sequencer that plays a programmable table of 8-bit values onto the Avalon-MM output PIO (s1 slave, 8-bit data_out register at address 0) at a fixed step period, so the Nios does not need to bit-bang timed patterns through software. It has its own Avalon-MM CSR slave (Nios side) and an Avalon-MM write-only master that connects to the PIO s1 port in Qsys. It supports single-shot or looped playback, stop, and a done interrupt.

## Interface
- DEPTH, 8: pattern table entries; legal range 1..8.
- DATA_W, 8: pattern width; matches the PIO out_port width.
- HOLD_W, 16: step-period counter width.

- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- s_address  in  4  CSR word address.
- s_chipselect  in  1  CSR select.
- s_write_n  in  1  CSR write strobe, active low.
- s_writedata  in  32  CSR write data.
- s_readdata  out  32  CSR read data; combinational from s_address, zero wait states.
- m_address  out  2  PIO word address; constant 0.
- m_chipselect  out  1  PIO select, registered.
- m_write_n  out  1  PIO write strobe, active low, registered.
- m_writedata  out  32  {zeros, pattern[DATA_W-1:0]}, registered.
- irq  out  1  done & irq_en, level.

## Operation
CSR map (s_chipselect && !s_write_n writes; unused bits read 0):
- 0 CTRL: bit0 START (write-1 pulse, reads 0), bit1 LOOP (r/w), bit2 STOP (write-1 pulse, reads 0), bit3 IRQ_EN (r/w).
- 1 STATUS: bit0 BUSY (ro), bit1 DONE (sticky; write 1 clears), bits[6:4] current index (ro).
- 2 LENGTH: bits[3:0], steps to play; values >DEPTH are clamped to DEPTH at START.
- 3 HOLD: bits[HOLD_W-1:0], cycles per step; 0 treated as 1.
- 8..8+DEPTH-1 PATTERN[i]: bits[DATA_W-1:0]. Other addresses read 0; writes to them are ignored.

FSM:
- IDLE: master idle. START && LENGTH!=0 -> WRITE with idx=0 and len latched. START with LENGTH==0 is ignored.
- WRITE (1 cycle): m_chipselect=1, m_write_n=0, m_writedata=PATTERN[idx]; load hold counter with max(HOLD,1)-1. If the count is 0, go to NEXT decision immediately; otherwise go to HOLD.
- HOLD: decrement each cycle; at 1 go to NEXT decision.
- NEXT decision (combinational, no extra cycle): if idx<len-1, increment idx and go to WRITE. Else if LOOP, set idx=0 and go to WRITE. Else set DONE and go to IDLE.
- STOP in any state forces IDLE on the next edge and issues no further writes. DONE is not set. A write already on the bus in that cycle completes.
- START while BUSY is ignored. START and STOP in the same write: STOP wins.
- PATTERN, HOLD, and LOOP writes while BUSY are allowed. PATTERN and HOLD are sampled when each WRITE state is entered. LOOP is sampled at the NEXT decision.
- DONE set and DONE clear in the same cycle: set wins.
- BUSY = (state != IDLE).

## Timing
- Reset values: all CSRs 0; state IDLE; idx 0; m_chipselect 0; m_write_n 1; m_address 0; m_writedata 0; irq 0; s_readdata follows address (0 for most addresses).
- START written on edge T: the WRITE cycle is T+1 (master signals valid between edges T+1 and T+2). The PIO out_port updates at edge T+2.
- Step period = max(HOLD,1) cycles, edge to edge, between consecutive PIO writes, including the loop wrap from len-1 to 0.
- HOLD=1: a write occurs every cycle.
- DONE and IRQ rise one cycle after the last step's period ends. That is the edge on which another step would have written.
- STOP written on edge S: the master is idle from cycle S+1.

## Test plan
- Reset: assert reset_n=0 mid-playback -> all outputs at reset values immediately; STATUS=0; out_port unchanged from the PIO's own reset.
- One-shot: PATTERN[0..2]=0x11,0x22,0x33, LENGTH=3, HOLD=4, START -> exactly 3 PIO writes, 4 cycles apart, in that order; DONE=1, BUSY=0 after 12 cycles; irq=1 only if IRQ_EN=1; write STATUS=0x2 -> DONE=0.
- HOLD=0 and HOLD=1, LENGTH=2 -> writes on consecutive cycles 0xA5,0x5A; no idle gap.
- Loop + STOP: LOOP=1, LENGTH=2, HOLD=3 -> sequence 0,1,0,1,… with a 3-cycle period; STOP -> no further writes after the current cycle, DONE stays 0.
- Edge cases: START with LENGTH=0 -> no write, BUSY stays 0. LENGTH=15 with DEPTH=8 -> 8 writes. START during BUSY -> ignored. START|STOP in the same write -> no playback.
- Live update: change PATTERN[1] while step 0 is holding -> the new value appears on step 1.
